// File: rtl/approx_mult_sched_pkg.sv
// Purpose : shared widths, helper function and pipeline record types for approx_mult_sched.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package approx_mult_pkg;

    localparam int OP_W       = 8;
    localparam int PROD_W     = 16;
    // The tag field is sized for the largest legal requester count (8).
    localparam int ID_MAX_W   = 3;
    // Partial-product columns below this weight are not summed by the approximate multiplier.
    localparam int TRUNC_COLS = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic [OP_W-1:0]     a;
        logic [OP_W-1:0]     b;
        logic [ID_MAX_W-1:0] id;
    } s1_rec_t;

    typedef struct packed {
        logic [PROD_W-1:0]   product;
        logic [ID_MAX_W-1:0] id;
    } s2_rec_t;

endpackage

// File: rtl/approx_mult_8bit.sv
// Purpose : 8x8 approximate multiplier; partial-product bits in the lowest TRUNC_COLS columns are dropped.
// Latency : combinational.
// Backpressure: none.
// Ports   : a, b operands; product = sum of shifted rows of b with the low columns masked off.
module approx_mult_8bit
    import approx_mult_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] product
);

    localparam logic [PROD_W-1:0] KEEP_MASK = ~PROD_W'((1 << TRUNC_COLS) - 1);

    // Row i is b shifted by i; masking each row drops every a[i]&b[j] term with i+j < TRUNC_COLS.
    always_comb begin
        product = '0;
        for (int i = 0; i < OP_W; i++) begin
            if (a[i]) product = product + (({{(PROD_W-OP_W){1'b0}}, b} << i) & KEEP_MASK);
        end
    end

endmodule

// File: rtl/approx_mult_sched_rr_arbiter.sv
// Purpose : round-robin request arbiter, search starts at ptr and wraps.
// Latency : combinational.
// Backpressure: none; caller qualifies grant with its own accept.
// Ports   : req, ptr in; one-hot grant, grant_idx and any out.
module rr_arbiter
    import approx_mult_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = (clog2(N) > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    // Two passes: indices at or above ptr first, then the wrapped indices below it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any       = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i < int'(ptr))) begin
                any       = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/approx_mult_sched.sv
// Purpose : shares one approx_mult_8bit between N_REQ requesters, round-robin, tagged response.
// Latency : accept at edge k -> rsp_valid after edge k+1; 1 product/cycle sustained.
// Backpressure: rsp_ready=0 with a held response freezes both stages and ptr; req_ready drops once S1 is full.
// Ports   : CLK_100MHZ, RST (sync, active-high); req_valid/req_a/req_b/req_ready per requester;
//           rsp_valid/rsp_id/rsp_product/rsp_ready response channel; busy; err_max (APPROX_ERR_MON_EN only).
// Option  : define APPROX_ERR_MON_EN to add an exact multiplier and the err_max running maximum.
module approx_mult_sched
    import approx_mult_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = (clog2(N_REQ) > 1) ? clog2(N_REQ) : 1
) (
    input  logic                    CLK_100MHZ,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [OP_W*N_REQ-1:0]   req_a,
    input  logic [OP_W*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [PROD_W-1:0]       rsp_product,
    input  logic                    rsp_ready,
    output logic                    busy
`ifdef APPROX_ERR_MON_EN
    ,
    output logic [PROD_W-1:0]       err_max
`endif
);

    s1_rec_t           s1;
    s2_rec_t           s2;
    logic              s1_v;
    logic              s2_v;
    logic [ID_W-1:0]   ptr;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;
    logic              adv2;
    logic              accept;
    logic              xfer;
    logic [OP_W-1:0]   sel_a;
    logic [OP_W-1:0]   sel_b;
    logic [PROD_W-1:0] approx_prod;
    logic              id_hi_unused;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    approx_mult_8bit u_mult (
        .a       (s1.a),
        .b       (s1.b),
        .product (approx_prod)
    );

    // S1 may refill in the same cycle S2 drains, so one stall signal covers both stages.
    assign adv2      = !s2_v || rsp_ready;
    assign accept    = !s1_v || adv2;
    assign req_ready = (accept && !RST) ? grant : '0;
    assign xfer      = grant_any && accept && !RST;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[OP_W*i +: OP_W];
                sel_b = req_b[OP_W*i +: OP_W];
            end
        end
    end

`ifdef APPROX_ERR_MON_EN
    logic [PROD_W-1:0] exact_prod;
    logic [PROD_W-1:0] err_cur;
    assign exact_prod = PROD_W'(s1.a) * PROD_W'(s1.b);
    assign err_cur    = (exact_prod >= approx_prod) ? (exact_prod - approx_prod)
                                                    : (approx_prod - exact_prod);
`endif

    always_ff @(posedge CLK_100MHZ) begin
        if (RST) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1   <= '0;
            s2   <= '0;
            ptr  <= '0;
`ifdef APPROX_ERR_MON_EN
            err_max <= '0;
`endif
        end else begin
            if (adv2) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2.product <= approx_prod;
                    s2.id      <= s1.id;
`ifdef APPROX_ERR_MON_EN
                    if (err_cur > err_max) err_max <= err_cur;
`endif
                end
            end
            if (accept) begin
                s1_v <= xfer;
                if (xfer) begin
                    s1.a  <= sel_a;
                    s1.b  <= sel_b;
                    s1.id <= ID_MAX_W'(grant_idx);
                end
            end
            if (xfer) begin
                ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign rsp_valid    = s2_v;
    assign rsp_id       = s2.id[ID_W-1:0];
    assign rsp_product  = s2.product;
    assign busy         = s1_v || s2_v;
    // Tag bits above ID_W are always zero.
    assign id_hi_unused = ^s2.id;

endmodule

// File: tb/tb_approx_mult_sched.sv
// Purpose : self-checking bench for approx_mult_sched (N_REQ=4); queue model plus directed literals.
// Latency : n/a.
// Backpressure: exercised through rsp_ready stalls.
module tb_approx_mult_sched;

    localparam int N = 4;

    logic            CLK_100MHZ = 1'b0;
    logic            RST;
    logic [N-1:0]    req_valid;
    logic [8*N-1:0]  req_a;
    logic [8*N-1:0]  req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [15:0]     rsp_product;
    logic            rsp_ready;
    logic            busy;
`ifdef APPROX_ERR_MON_EN
    logic [15:0]     err_max;
`endif

    always #5 CLK_100MHZ = ~CLK_100MHZ;

    approx_mult_sched #(.N_REQ(N)) dut (
        .CLK_100MHZ  (CLK_100MHZ),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_ready   (rsp_ready),
        .busy        (busy)
`ifdef APPROX_ERR_MON_EN
        ,
        .err_max     (err_max)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Exact product minus every a[i]&b[j] term whose weight 2^(i+j) is below 16.
    function automatic logic [15:0] model_approx(input logic [7:0] a, input logic [7:0] b);
        int exact;
        int dropped;
        exact   = int'(a) * int'(b);
        dropped = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4 - i; j++)
                if (a[i] && b[j]) dropped += (1 << (i + j));
        return 16'(exact - dropped);
    endfunction

    // Model: a two-entry in-order queue; an entry becomes visible one edge after it is accepted.
    typedef struct {
        int          id;
        logic [15:0] prod;
        bit          vis;
    } item_t;

    item_t q[$];
    int    resp_log[$];
    int    mptr       = 0;
    bit    known      = 1'b0;
    int    m_err_max  = 0;

    always @(negedge CLK_100MHZ) begin
        bit          exp_rv;
        bit          exp_acc;
        int          g;
        int          idx;
        logic [N-1:0] exp_rdy;
        logic [7:0]  ga;
        logic [7:0]  gb;
        item_t       it;

        exp_rv  = known && (q.size() > 0) && q[0].vis;
        exp_acc = (q.size() < 2) || (exp_rv && rsp_ready);
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (mptr + k) % N;
            if (g < 0 && req_valid[idx[1:0]]) g = idx;
        end
        exp_rdy = '0;
        if (!RST && exp_acc && g >= 0) exp_rdy = N'(1) << g;

        if (known || RST) chk("mdl_req_ready", 32'(req_ready), 32'(exp_rdy));
        if (known) begin
            chk("mdl_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("mdl_busy", 32'(busy), 32'(q.size() > 0));
            if (exp_rv) begin
                chk("mdl_rsp_id", 32'(rsp_id), 32'(q[0].id));
                chk("mdl_rsp_product", 32'(rsp_product), 32'(q[0].prod));
            end
        end

        if (RST) begin
            q.delete();
            mptr      = 0;
            m_err_max = 0;
            known     = 1'b1;
        end else if (known) begin
            if (exp_rv && rsp_ready) begin
                resp_log.push_back(q[0].id);
                void'(q.pop_front());
            end
            foreach (q[i]) q[i].vis = 1'b1;
            if (exp_rdy != '0) begin
                ga      = 8'(req_a >> (8 * g));
                gb      = 8'(req_b >> (8 * g));
                it.id   = g;
                it.prod = model_approx(ga, gb);
                it.vis  = 1'b0;
                q.push_back(it);
                if (int'(ga) * int'(gb) - int'(it.prod) > m_err_max)
                    m_err_max = int'(ga) * int'(gb) - int'(it.prod);
                mptr = (g + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge CLK_100MHZ);
        #1;
    endtask

    task automatic set_ops();
        for (int i = 0; i < N; i++) begin
            req_a[8*i +: 8] = 8'(8'h10 + i);
            req_b[8*i +: 8] = 8'(8'h21 + 3 * i);
        end
    endtask

    initial begin
        logic [3:0] exp_g [5];
        int         exp_id [5];
        int         accepts;

        exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_id = '{0, 1, 2, 3, 0};

        RST = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (3) step();
        RST = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_product", 32'(rsp_product), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("model_pin_0f03", 32'(model_approx(8'h0F, 8'h03)), 32'h0010);

        // single request, first-transaction latency
        req_valid = 4'b0001; req_a[7:0] = 8'h0F; req_b[7:0] = 8'h03;
        #1;
        chk("t1_req_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        #1;
        chk("t1_not_yet_valid", 32'(rsp_valid), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        step();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_id", 32'(rsp_id), 32'd0);
        chk("t1_rsp_product", 32'(rsp_product), 32'h0010);

        // all-ones operands: every dropped term is present (49 lost)
        req_valid = 4'b0001; req_a[7:0] = 8'hFF; req_b[7:0] = 8'hFF;
        step();
        req_valid = '0;
        step();
        chk("t1_ffff_product", 32'(rsp_product), 32'hFDD0);
        repeat (2) step();

        // all four requesting continuously
        RST = 1'b1;
        step();
        RST = 1'b0;
        resp_log.delete();
        set_ops();
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t2_grant", 32'(req_ready), 32'(exp_g[c]));
            if (c >= 2) begin
                chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("t2_rsp_id", 32'(rsp_id), 32'(exp_id[c-2]));
            end
            step();
        end
        req_valid = '0;
        repeat (4) step();
        chk("t2_resp_count", 32'(resp_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < resp_log.size(); i++)
            chk("t2_resp_order", 32'(resp_log[i]), 32'(exp_id[i]));

        // stall: ptr is 1 here
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        accepts   = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (req_ready != '0) accepts++;
            if (c == 0) chk("t3_grant0", 32'(req_ready), 32'b0010);
            if (c == 1) chk("t3_grant1", 32'(req_ready), 32'b0100);
            if (c >= 2) begin
                chk("t3_stalled_ready", 32'(req_ready), 32'd0);
                chk("t3_held_valid", 32'(rsp_valid), 32'd1);
                chk("t3_held_id", 32'(rsp_id), 32'd1);
                chk("t3_held_product", 32'(rsp_product), 32'(model_approx(8'h11, 8'h24)));
            end
            step();
        end
        chk("t3_accepts", 32'(accepts), 32'd2);
        req_valid = '0; rsp_ready = 1'b1;
        #1;
        chk("t3_drain_id0", 32'(rsp_id), 32'd1);
        step();
        chk("t3_drain_valid1", 32'(rsp_valid), 32'd1);
        chk("t3_drain_id1", 32'(rsp_id), 32'd2);
        step();
        chk("t3_empty_valid", 32'(rsp_valid), 32'd0);
        chk("t3_empty_busy", 32'(busy), 32'd0);

        // wrap search from ptr=3
        RST = 1'b1;
        step();
        RST = 1'b0;
        req_valid = 4'b0100;
        #1;
        chk("t4_grant_first", 32'(req_ready), 32'b0100);
        step();
        chk("t4_grant_wrap", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b1100;
        #1;
        chk("t4_ptr_is_3", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        repeat (3) step();

        // reset with both stages full
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        repeat (2) step();
        chk("t5_full_busy", 32'(busy), 32'd1);
        RST = 1'b1;
        #1;
        chk("t5_rst_ready", 32'(req_ready), 32'd0);
        step();
        RST = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1;
        #1;
        chk("t5_flush_valid", 32'(rsp_valid), 32'd0);
        chk("t5_flush_busy", 32'(busy), 32'd0);
        chk("t5_first_grant", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        repeat (3) step();

`ifdef APPROX_ERR_MON_EN
        RST = 1'b1;
        step();
        RST = 1'b0;
        req_valid = 4'b0001;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                req_a[7:0] = 8'(ai * 17);
                req_b[7:0] = 8'(bi * 17);
                step();
            end
        end
        req_valid = '0;
        repeat (3) step();
        chk("t6_err_max_model", 32'(err_max), 32'(m_err_max));
        chk("t6_err_max_literal", 32'(err_max), 32'd49);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
